// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: host-tx state encoding, error codes, default timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_PARITY    = 3'd4,
    ST_STOP      = 3'd5,
    ST_ACK       = 3'd6,
    ST_WAIT_IDLE = 3'd7
  } ps2_tx_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  // 120 us request-to-send and 15 ms edge-to-edge limit at 50 MHz
  localparam int INHIBIT_CYCLES_DEF = 6000;
  localparam int TIMEOUT_CYCLES_DEF = 750000;

  // PS/2 frames carry odd parity over the 8 data bits
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pin conditioning: 2-FF synchronisers on clock and data plus a registered falling-edge strobe.
// Latency: synced levels 2 cycles after the pin, clk_fall strobe 3 cycles after the pin edge.
// Backpressure: none; free-running on every clkin cycle.
module ps2_line_sync (
  input  logic clkin,
  input  logic rstn,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_prev;

  // Idle bus is high, so reset to 1 to avoid a false edge when reset lifts
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      clk_prev <= 1'b1;
      clk_fall <= 1'b0;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_in};
      dat_ff   <= {dat_ff[0], ps2_dat_in};
      clk_prev <= clk_ff[1];
      clk_fall <= clk_prev & ~clk_ff[1];
    end
  end

  assign clk_s = clk_ff[1];
  assign dat_s = dat_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: RTS inhibit, 11-bit frame clocked by the device, ACK check.
// Latency: clock pulled 1 cycle after accept; data changes 1 cycle after each synced falling-edge strobe.
// Backpressure: tx_ready only in IDLE outside a done/err pulse; tx_valid while busy is ignored, no queueing.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clkin,
  input  logic       rstn,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  output logic       rx_inhibit
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic clk_s, dat_s, clk_fall;

  ps2_line_sync u_sync (
    .clkin      (clkin),
    .rstn       (rstn),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_s      (clk_s),
    .dat_s      (dat_s),
    .clk_fall   (clk_fall)
  );

  ps2_tx_state_t    state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             parity_q, parity_d;
  logic             ack_q, ack_d;
  logic [2:0]       bits_q, bits_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             clk_oe_d, dat_oe_d, done_d, err_d;
  logic [1:0]       code_d;
  logic             timing;

  // The pulse cycle itself is not ready, so a new accept lands the cycle after done/err
  assign tx_ready   = (state_q == ST_IDLE) && !tx_done && !tx_err;
  assign rx_inhibit = (state_q != ST_IDLE);

  // State and registered pin/status outputs; async reset releases both lines immediately
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      ack_q      <= 1'b1;
      bits_q     <= '0;
      inh_q      <= '0;
      to_q       <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      ack_q      <= ack_d;
      bits_q     <= bits_d;
      inh_q      <= inh_d;
      to_q       <= to_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
      tx_done    <= done_d;
      tx_err     <= err_d;
      err_code   <= code_d;
    end
  end

  // Next-state, frame shifting, edge-to-edge timeout and next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    ack_d    = ack_q;
    bits_d   = bits_q;
    inh_d    = inh_q;
    to_d     = to_q;
    clk_oe_d = ps2_clk_oe;
    dat_oe_d = ps2_dat_oe;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = err_code;

    // Device-paced states are the ones guarded by the timeout
    timing = (state_q != ST_IDLE) && (state_q != ST_INHIBIT);
    if (timing) begin
      to_d = clk_fall ? '0 : to_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          shreg_d  = tx_data;
          parity_d = odd_parity(tx_data);
          inh_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        inh_d = inh_q + 1'b1;
        // Start bit goes low one cycle before the clock is let go
        if (inh_q == INH_LAST - 1'b1) begin
          dat_oe_d = 1'b1;
        end
        if (inh_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          to_d     = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (clk_fall) begin
          dat_oe_d = ~shreg_q[0];
          shreg_d  = shreg_q >> 1;
          bits_d   = 3'd7;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_fall) begin
          if (bits_q != 3'd0) begin
            dat_oe_d = ~shreg_q[0];
            shreg_d  = shreg_q >> 1;
            bits_d   = bits_q - 1'b1;
          end else begin
            dat_oe_d = ~parity_q;
            state_d  = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          dat_oe_d = 1'b0;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        // 11th falling edge: the device should be holding data low as ACK
        if (clk_fall) begin
          ack_d   = dat_s;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (ack_q) begin
          err_d   = 1'b1;
          code_d  = ERR_NOACK;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A falling edge in the expiry cycle wins over the timeout
    if (timing && !clk_fall && (to_q == TO_LAST) && !done_d && !err_d) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      err_d    = 1'b1;
      code_d   = ERR_TIMEOUT;
      state_d  = ST_IDLE;
    end
  end

endmodule
